adc_dac_loop: RTL and testbench
===============================

Name: adc_dac_loop

Overview:
Parametrised ADC-to-DAC sample loop, the successor to the fixed 12-to-8-bit passthrough top-level.
- Drives the ADC wrapper START and detects VALID through a synchroniser.
- Optionally averages 2^AVG_LOG2 conversions, then rounds and saturates to DAC width.
- Registers the result onto the DAC wrapper VALUE.
- Adds enable/abort control, a conversion timeout with a sticky error flag, and an update strobe for fabric logic.

Parameters:
ADC_W, 12, ADC sample width; must be > DAC_W.
DAC_W, 8, DAC code width.
AVG_LOG2, 2, log2 of averaging depth when avg_en=1; legal range 0..4.
SYNC_STAGES, 2, flops in the adc_valid synchroniser; minimum 2.
TIMEOUT_CYCLES, 1024, clk cycles in WAIT before a conversion is declared lost.

Ports:
clk  in  1  fabric clock
reset  in  1  asynchronous, active-high reset (from WARMBOOT wrapper RESET)
enable  in  1  run loop while 1
avg_en  in  1  1: average 2^AVG_LOG2 samples; 0: single-sample passthrough
err_clr  in  1  clears timeout_err
adc_start  out  1  to ADC wrapper START
adc_valid  in  1  from ADC wrapper VALID; asynchronous level
adc_value  in  ADC_W  from ADC wrapper VALUE; stable while adc_valid=1
dac_value  out  DAC_W  to DAC wrapper VALUE
dac_update  out  1  one-cycle pulse when dac_value changes
timeout_err  out  1  sticky conversion-timeout flag
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (async assert, clocked deassert):
  - Outputs: dac_value=0, dac_update=0, timeout_err=0, adc_start=0, busy=0.
  - Internal: state=IDLE; accumulator, sample count and timeout counter = 0; synchroniser flops = 0.
- Valid detection:
  - adc_valid passes through SYNC_STAGES flops; one more flop holds the previous synchronised value.
  - An accepted edge is synchronised=1 while previous=0, in state WAIT only.
  - Edges in other states are ignored.
- States:
  - IDLE: adc_start=0. Go to RESTART when enable=1.
  - RESTART: adc_start=0 for exactly one cycle, to retrigger the ADC; timeout counter cleared. Then go to WAIT.
  - WAIT: adc_start=1; the timeout counter increments each cycle.
    - On an accepted edge: acc += adc_value (zero-extended), count++.
    - Last sample is count == 2^AVG_LOG2-1, or any sample when avg_en=0. Last sample -> OUTPUT; otherwise -> RESTART.
    - If the timeout counter reaches TIMEOUT_CYCLES-1 with no edge: timeout_err<=1, acc and count cleared, -> RESTART.
  - OUTPUT: one cycle.
    - dac_value<=result and dac_update<=1 at the exiting edge; dac_update is high for exactly the following cycle.
    - acc and count cleared.
    - Next state: RESTART if enable=1, else IDLE.
- Latency: dac_update asserts 2 clk after the synchronised edge on the last sample.
- enable=0 in RESTART or WAIT: next cycle go to IDLE, acc and count cleared, dac_value held. A partial average is never output.
- avg_en is sampled only at the start of each average, i.e. when count==0. A change mid-average takes effect on the next average.
- Arithmetic:
  - Accumulator width is ADC_W+AVG_LOG2; it cannot overflow.
  - avg = acc >> AVG_LOG2 (averaging) or the single sample (passthrough).
  - result = (avg + 2^(ADC_W-DAC_W-1)) >> (ADC_W-DAC_W), computed ADC_W+1 wide.
  - Saturate to 2^DAC_W-1 if the rounded value overflows DAC_W.
- timeout_err:
  - Set by a timeout, cleared by err_clr=1.
  - A set and a clear in the same cycle resolve to set.
  - The loop keeps running regardless of timeout_err.

Decomposition:
- Package adc_dac_pkg holds:
  - state enum: IDLE, RESTART, WAIT, OUTPUT
  - function round_sat(avg, ADC_W, DAC_W)
  - localparam ACC_W
- Sub-module adc_dac_sync: an SYNC_STAGES-deep synchroniser with a rising-edge-detect output, reusable for other macro handshakes.

Test Plan:
1. Default params, avg_en=0, one conversion of 0xABC -> dac_value=0xAC with a one-cycle dac_update, 2 clk after the synchronised edge.
2. avg_en=0, sample 0xFFC -> rounded 0x100 saturates -> dac_value=0xFF; sample 0x007 -> 0x00; sample 0x008 -> 0x01.
3. avg_en=1, AVG_LOG2=2, samples 0x100, 0x110, 0x120, 0x130 -> a single dac_update, dac_value=0x12; no update after samples 1-3; adc_start low one cycle between samples.
4. adc_valid held low in WAIT for 1024 cycles -> timeout_err=1, adc_start drops one cycle and then re-rises; err_clr pulse -> 0; err_clr in the same cycle as a new timeout -> stays 1.
5. enable=0 after 2 of 4 averaged samples -> IDLE, busy=0, dac_value unchanged; re-enable, then 4 samples of 0x800 -> dac_value=0x80 (no stale partial sum).
6. Assert reset mid-WAIT, asynchronously between clk edges -> all outputs 0 immediately; adc_valid left high across deassert -> no spurious sample accepted until a fresh edge.

Source files
------------

// File: rtl/adc_dac_pkg.sv
// Shared types, defaults and arithmetic helpers for the ADC-to-DAC loop.
package adc_dac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTART = 2'd1,
    WAIT    = 2'd2,
    OUTPUT  = 2'd3
  } state_e;

  localparam int DEF_ADC_W    = 12;
  localparam int DEF_DAC_W    = 8;
  localparam int DEF_AVG_LOG2 = 2;
  localparam int ACC_W        = DEF_ADC_W + DEF_AVG_LOG2;

  // Round half-up from adc_w to dac_w bits, clamping the carry-out case.
  function automatic logic [31:0] round_sat(
    input logic [31:0] avg,
    input int          adc_w,
    input int          dac_w
  );
    logic [31:0] r;
    logic [31:0] mx;
    r  = (avg + (32'd1 << (adc_w - dac_w - 1))) >> (adc_w - dac_w);
    mx = (32'd1 << dac_w) - 32'd1;
    return (r > mx) ? mx : r;
  endfunction

endpackage

// File: rtl/adc_dac_sync.sv
// Multi-flop level synchroniser with a registered-history rising-edge flag.
module adc_dac_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc_dac_loop.sv
// ADC-to-DAC sample loop: retriggers the ADC, optionally averages,
// rounds/saturates and registers the result onto the DAC.
module adc_dac_loop
  import adc_dac_pkg::*;
#(
  parameter int ADC_W          = DEF_ADC_W,
  parameter int DAC_W          = DEF_DAC_W,
  parameter int AVG_LOG2       = DEF_AVG_LOG2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             avg_en,
  input  logic             err_clr,
  output logic             adc_start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_value,
  output logic [DAC_W-1:0] dac_value,
  output logic             dac_update,
  output logic             timeout_err,
  output logic             busy
);

  localparam int AW = ADC_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             mode_q, mode_d;
  logic [DAC_W-1:0] dac_q, dac_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             rise;
  logic             last;
  logic [AW-1:0]    avg;

  adc_dac_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (adc_valid),
    .rise_o  (rise)
  );

  // avg_en only counts at the first sample of an average.
  assign mode_d = (cnt_q == '0) ? avg_en : mode_q;
  assign last   = mode_d ? (cnt_q == LAST_CNT) : 1'b1;
  assign avg    = mode_q ? (acc_q >> AVG_LOG2) : acc_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    dac_d   = dac_q;
    upd_d   = 1'b0;
    err_d   = err_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = RESTART;
      end
      RESTART: begin
        tmo_d = '0;
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (!enable) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (rise) begin
          acc_d   = acc_q + AW'(adc_value);
          cnt_d   = cnt_q + 1'b1;
          state_d = last ? OUTPUT : RESTART;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RESTART;
        end
      end
      OUTPUT: begin
        dac_d   = DAC_W'(round_sat(32'(avg), ADC_W, DAC_W));
        upd_d   = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = enable ? RESTART : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered so START is glitch-free at the ADC wrapper.
  assign start_d = (state_d == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      mode_q  <= 1'b0;
      dac_q   <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      mode_q  <= mode_d;
      dac_q   <= dac_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign adc_start   = start_q;
  assign dac_value   = dac_q;
  assign dac_update  = upd_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_adc_dac_loop.sv
// Bench for adc_dac_loop: vector table, scoreboard monitor, and
// hand-built timeout / abort / reset sequences.
module tb_adc_dac_loop;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        avg_en;
  logic        err_clr;
  logic        adc_start;
  logic        adc_valid;
  logic [11:0] adc_value;
  logic [7:0]  dac_value;
  logic        dac_update;
  logic        timeout_err;
  logic        busy;

  adc_dac_loop dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avg_en      (avg_en),
    .err_clr     (err_clr),
    .adc_start   (adc_start),
    .adc_valid   (adc_valid),
    .adc_value   (adc_value),
    .dac_value   (dac_value),
    .dac_update  (dac_update),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  typedef struct {
    logic              avg;
    int                n;
    logic [3:0][11:0]  s;
    logic [7:0]        exp_v;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         n_upd = 0;
  logic [7:0] last_exp = 8'h00;
  logic       prev_upd = 1'b0;
  logic [7:0] sb[$];
  vec_t       vt[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic a, input int n,
                              input logic [11:0] s0, input logic [11:0] s1,
                              input logic [11:0] s2, input logic [11:0] s3,
                              input logic [7:0] e);
    vec_t v;
    v.avg   = a;
    v.n     = n;
    v.s[0]  = s0;
    v.s[1]  = s1;
    v.s[2]  = s2;
    v.s[3]  = s3;
    v.exp_v = e;
    return v;
  endfunction

  // Scoreboard monitor: every update must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && dac_update) begin
      n_upd++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update: got %0h want none", dac_value);
      end else begin
        last_exp = sb.pop_front();
        chk("dac_value", dac_value, last_exp);
      end
      chk("upd_width", prev_upd, 0);
    end
    prev_upd = dac_update;
  end

  // One ADC conversion: wait for START, present data, raise VALID.
  task automatic conv(input logic [11:0] v, output int lat, output int lows);
    for (int k = 0; k < 100 && !adc_start; k++) @(negedge clk);
    chk("start_wait", adc_start, 1);
    repeat (2) @(negedge clk);
    adc_value = v;
    adc_valid = 1'b1;
    lat  = 0;
    lows = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (dac_update && lat == 0) lat = i;
      if (!adc_start) lows++;
    end
    adc_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #(300000 * 10);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int lows;
    int cnt;
    int upd0;

    vt[0] = mk(1'b0, 1, 12'hABC, 12'h0, 12'h0, 12'h0, 8'hAC);
    vt[1] = mk(1'b0, 1, 12'hFFC, 12'h0, 12'h0, 12'h0, 8'hFF);
    vt[2] = mk(1'b0, 1, 12'h007, 12'h0, 12'h0, 12'h0, 8'h00);
    vt[3] = mk(1'b0, 1, 12'h008, 12'h0, 12'h0, 12'h0, 8'h01);
    vt[4] = mk(1'b1, 4, 12'h100, 12'h110, 12'h120, 12'h130, 8'h12);
    vt[5] = mk(1'b1, 4, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 8'hFF);
    vt[6] = mk(1'b0, 1, 12'h7F8, 12'h0, 12'h0, 12'h0, 8'h80);
    vt[7] = mk(1'b0, 1, 12'h7F7, 12'h0, 12'h0, 12'h0, 8'h7F);
    vt[8] = mk(1'b1, 4, 12'h000, 12'h001, 12'h002, 12'h003, 8'h00);
    vt[9] = mk(1'b1, 4, 12'h010, 12'h010, 12'h010, 12'h00F, 8'h01);

    reset     = 1'b1;
    enable    = 1'b0;
    avg_en    = 1'b0;
    err_clr   = 1'b0;
    adc_valid = 1'b0;
    adc_value = 12'h0;

    repeat (2) @(negedge clk);
    chk("rst_dac", dac_value, 0);
    chk("rst_upd", dac_update, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_start", adc_start, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_start", adc_start, 0);
    enable = 1'b1;

    for (int v = 0; v < 10; v++) begin
      avg_en = vt[v].avg;
      for (int j = 0; j < vt[v].n; j++) begin
        if (j == vt[v].n - 1) sb.push_back(vt[v].exp_v);
        conv(vt[v].s[j], lat, lows);
        if (j == vt[v].n - 1) begin
          chk($sformatf("v%0d_lat", v), lat, 4);
        end else begin
          chk($sformatf("v%0d_s%0d_noupd", v, j), lat, 0);
          chk($sformatf("v%0d_s%0d_startlow", v, j), lows, 1);
        end
      end
    end

    chk("err_before_tmo", timeout_err, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    cnt = 0;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (timeout_err) break;
      if (adc_start) cnt++;
    end
    chk("tmo_err_set", timeout_err, 1);
    chk("tmo_wait_cycles", cnt, 1024);
    chk("tmo_start_drop", adc_start, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("tmo_start_rerise", adc_start, 1);
    chk("err_cleared", timeout_err, 0);
    err_clr = 1'b1;
    for (int k = 0; k < 1200 && adc_start; k++) @(negedge clk);
    chk("tmo2_start_drop", adc_start, 0);
    chk("err_set_wins", timeout_err, 1);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_sticky", timeout_err, 1);

    avg_en = 1'b1;
    conv(12'h3FF, lat, lows);
    chk("abort_s0_noupd", lat, 0);
    conv(12'h3FF, lat, lows);
    chk("abort_s1_noupd", lat, 0);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_start", adc_start, 0);
    chk("abort_dac_held", dac_value, last_exp);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) sb.push_back(8'h80);
      conv(12'h800, lat, lows);
      chk($sformatf("fresh_s%0d_lat", j), lat, (j == 3) ? 4 : 0);
    end

    avg_en = 1'b0;
    for (int k = 0; k < 100 && !adc_start; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    adc_value = 12'hFFF;
    adc_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_dac", dac_value, 0);
    chk("arst_upd", dac_update, 0);
    chk("arst_err", timeout_err, 0);
    chk("arst_start", adc_start, 0);
    chk("arst_busy", busy, 0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    upd0 = n_upd;
    repeat (30) @(negedge clk);
    chk("no_spurious_upd", n_upd, upd0);
    chk("still_wait_start", adc_start, 1);
    chk("still_wait_busy", busy, 1);
    adc_valid = 1'b0;
    repeat (4) @(negedge clk);
    sb.push_back(8'h88);
    conv(12'h87F, lat, lows);
    chk("post_rst_lat", lat, 4);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
